// File: rtl/icache_assoc.sv
// Set-associative instruction cache: whole-line hits from local storage, misses filled over irequest/ireqack/idone.
// Hit returns two cycles after accept; misses wait on memory, round-robin victim when no invalid way exists.
module icache_assoc #(
  parameter int WAYS        = 2,
  parameter int SET_BITS    = 6,
  parameter int OFFSET_BITS = 6,
  parameter int ADDR_WIDTH  = 64,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [ADDR_WIDTH-1:0]        addr,
  input  logic                         flush,
  output logic [(8<<OFFSET_BITS)-1:0]  rdata,
  output logic                         done,
  output logic                         irequest,
  input  logic                         ireqack,
  output logic [ADDR_WIDTH-1:0]        iaddr,
  input  logic [(8<<OFFSET_BITS)-1:0]  idata,
  input  logic                         idone,
  output logic [CNT_WIDTH-1:0]         hit_count,
  output logic [CNT_WIDTH-1:0]         miss_count
);

  localparam int LINE_W = 8 << OFFSET_BITS;
  localparam int SETS   = 1 << SET_BITS;
  localparam int TAG_W  = ADDR_WIDTH - SET_BITS - OFFSET_BITS;
  localparam int PTR_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = {{(ADDR_WIDTH-OFFSET_BITS){1'b0}}, {OFFSET_BITS{1'b1}}};

  typedef enum logic [1:0] {IDLE, LOOKUP, MISS} state_t;
  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0]        line_addr;
  logic [SET_BITS-1:0]          set_idx;
  logic [TAG_W-1:0]             tag_in;
  logic [SETS-1:0][WAYS-1:0]    valid;
  logic [SETS-1:0][PTR_W-1:0]   rr_ptr;
  logic [TAG_W-1:0]             tag_mem  [SETS][WAYS];
  logic [LINE_W-1:0]            data_mem [SETS][WAYS];

  logic [WAYS-1:0]  match;
  logic             hit;
  logic [PTR_W-1:0] hit_way;
  logic [PTR_W-1:0] victim;
  logic             has_invalid;
  logic [PTR_W-1:0] ptr_next;

  assign set_idx = line_addr[OFFSET_BITS +: SET_BITS];
  assign tag_in  = line_addr[ADDR_WIDTH-1 -: TAG_W];

  always_comb begin
    match   = '0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      match[w] = valid[set_idx][w] && (tag_mem[set_idx][w] == tag_in);
      if (match[w]) hit_way = PTR_W'(w);
    end
  end

  // Only a single matching way counts as a hit; a duplicate match is never produced by fills.
  assign hit = (match != '0) && ((match & (match - 1'b1)) == '0);

  // Descending scan leaves the lowest-index invalid way as victim.
  always_comb begin
    victim      = rr_ptr[set_idx];
    has_invalid = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[set_idx][w]) begin
        victim      = PTR_W'(w);
        has_invalid = 1'b1;
      end
    end
  end

  assign ptr_next = (rr_ptr[set_idx] == PTR_W'(WAYS - 1)) ? '0 : rr_ptr[set_idx] + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!flush && enable) state_nxt = LOOKUP;
      LOOKUP:  state_nxt = hit ? IDLE : MISS;
      MISS:    if (idone) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done       <= 1'b0;
      rdata      <= '0;
      irequest   <= 1'b0;
      iaddr      <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      valid      <= '0;
      rr_ptr     <= '0;
      line_addr  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (flush) begin
            valid  <= '0;
            rr_ptr <= '0;
          end else if (enable) begin
            line_addr <= addr & ~OFF_MASK;
          end
        end
        LOOKUP: begin
          if (hit) begin
            rdata     <= data_mem[set_idx][hit_way];
            done      <= 1'b1;
            hit_count <= hit_count + 1'b1;
          end else begin
            irequest <= 1'b1;
            iaddr    <= line_addr;
          end
        end
        MISS: begin
          if (idone) begin
            valid[set_idx][victim] <= 1'b1;
            if (!has_invalid) rr_ptr[set_idx] <= ptr_next;
            rdata      <= idata;
            done       <= 1'b1;
            miss_count <= miss_count + 1'b1;
            irequest   <= 1'b0;
          end else if (ireqack) begin
            irequest <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Line storage carries no reset so it can map onto RAM; valid bits gate its use.
  always_ff @(posedge clk) begin
    if (!reset && state == MISS && idone) begin
      tag_mem[set_idx][victim]  <= tag_in;
      data_mem[set_idx][victim] <= idata;
    end
  end

endmodule

// File: tb/tb_icache_assoc.sv
// Scoreboard bench for icache_assoc: expected lines queued at request time, popped when done is seen.
module tb_icache_assoc;

  localparam int LW = 512;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [63:0]   addr = '0;
  logic          flush = 1'b0;
  logic [LW-1:0] rdata;
  logic          done;
  logic          irequest;
  logic          ireqack = 1'b0;
  logic [63:0]   iaddr;
  logic [LW-1:0] idata = '0;
  logic          idone = 1'b0;
  logic [31:0]   hit_count;
  logic [31:0]   miss_count;

  int vectors = 0;
  int miscompares = 0;
  int exp_hits = 0;
  int exp_misses = 0;
  logic [LW-1:0] exp_q[$];
  logic [LW-1:0] mon_exp;

  icache_assoc dut (
    .clk(clk), .reset(reset), .enable(enable), .addr(addr), .flush(flush),
    .rdata(rdata), .done(done), .irequest(irequest), .ireqack(ireqack),
    .iaddr(iaddr), .idata(idata), .idone(idone),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  function automatic logic [LW-1:0] pat(input logic [63:0] a);
    logic [63:0] la;
    la = a & ~64'h3F;
    return {4{la ^ 64'hC3C3_0000_5A5A_0000, ~la}};
  endfunction

  // Every done must consume exactly one queued expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_done rdata=%h", rdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if (rdata !== mon_exp) begin
          miscompares++;
          $display("FAIL rdata got=%h want=%h", rdata, mon_exp);
        end
      end
    end
  end

  task automatic do_access(input logic [63:0] a, input bit same_ack, output int lat,
                           output bit missed, output logic [63:0] req_addr, output bit irq_after_ack);
    bit acked;
    acked = 0; missed = 0; req_addr = '0; irq_after_ack = 1'b1; lat = -1;
    exp_q.push_back(pat(a));
    @(negedge clk); enable = 1'b1; addr = a;
    @(negedge clk); enable = 1'b0;
    for (int c = 2; c < 40; c++) begin
      @(negedge clk);
      ireqack = 1'b0; idone = 1'b0;
      if (done) begin lat = c; break; end
      if (acked) begin
        irq_after_ack = irequest;
        idone = 1'b1; idata = pat(a); acked = 0;
      end else if (irequest && !missed) begin
        missed = 1; req_addr = iaddr; ireqack = 1'b1;
        if (same_ack) begin idone = 1'b1; idata = pat(a); irq_after_ack = 1'b0; end
        else acked = 1;
      end
    end
    if (lat < 0) exp_q.delete();
  endtask

  task automatic check_counts(input string tag);
    vectors++;
    if (hit_count !== 32'(exp_hits) || miss_count !== 32'(exp_misses)) begin
      miscompares++;
      $display("FAIL %s counts got=%0d/%0d want=%0d/%0d", tag, hit_count, miss_count, exp_hits, exp_misses);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (done !== 1'b0 || irequest !== 1'b0) begin
      miscompares++; $display("FAIL reset_ctrl got done=%b irequest=%b want 0/0", done, irequest);
    end
    vectors++;
    if (iaddr !== 64'h0) begin miscompares++; $display("FAIL reset_iaddr got=%h want=0", iaddr); end
    vectors++;
    if (rdata !== '0) begin miscompares++; $display("FAIL reset_rdata got=%h want=0", rdata); end
    check_counts("reset");
    reset = 1'b0;
  endtask

  task automatic test_cold_miss;
    int lat; bit missed; logic [63:0] ra; bit iaa;
    do_access(64'h1040, 1'b0, lat, missed, ra, iaa);
    exp_misses++;
    vectors++;
    if (missed !== 1'b1 || ra !== 64'h1040) begin
      miscompares++; $display("FAIL cold_req got missed=%b iaddr=%h want 1/1040", missed, ra);
    end
    vectors++;
    if (iaa !== 1'b0) begin miscompares++; $display("FAIL irequest_drop got=%b want=0", iaa); end
    vectors++;
    if (lat !== 4) begin miscompares++; $display("FAIL miss_latency got=%0d want=4", lat); end
    check_counts("cold_miss");
  endtask

  task automatic test_hit;
    int lat; bit missed; logic [63:0] ra; bit iaa;
    logic [63:0] hit_addrs [2];
    hit_addrs[0] = 64'h1040; hit_addrs[1] = 64'h1075;
    for (int i = 0; i < 2; i++) begin
      do_access(hit_addrs[i], 1'b0, lat, missed, ra, iaa);
      exp_hits++;
      vectors++;
      if (missed !== 1'b0 || lat !== 2) begin
        miscompares++; $display("FAIL hit_%h got missed=%b lat=%0d want 0/2", hit_addrs[i], missed, lat);
      end
      check_counts("hit");
      @(negedge clk);
      vectors++;
      if (done !== 1'b0) begin miscompares++; $display("FAIL done_pulse got=%b want=0", done); end
    end
  endtask

  task automatic test_conflict;
    int lat; bit missed; logic [63:0] ra; bit iaa;
    logic [63:0] ca [7];
    bit ch [7];
    ca = '{64'h0000, 64'h1000, 64'h2000, 64'h1000, 64'h0000, 64'h2000, 64'h1000};
    ch = '{0, 0, 0, 1, 0, 1, 0};
    for (int i = 0; i < 7; i++) begin
      do_access(ca[i], (i == 1), lat, missed, ra, iaa);
      if (ch[i]) exp_hits++; else exp_misses++;
      vectors++;
      if (missed !== !ch[i]) begin
        miscompares++; $display("FAIL conflict_%0d addr=%h got missed=%b want=%b", i, ca[i], missed, !ch[i]);
      end
      vectors++;
      if (!ch[i] && (ra !== ca[i] || lat !== (i == 1 ? 3 : 4))) begin
        miscompares++; $display("FAIL conflict_req_%0d got iaddr=%h lat=%0d", i, ra, lat);
      end
    end
    check_counts("conflict");
  endtask

  task automatic test_flush;
    int lat; bit missed; logic [63:0] ra; bit iaa; bit seen;
    do_access(64'h1040, 1'b0, lat, missed, ra, iaa);
    exp_hits++;
    vectors++;
    if (missed !== 1'b0) begin miscompares++; $display("FAIL preflush got missed=%b want=0", missed); end
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    do_access(64'h1040, 1'b0, lat, missed, ra, iaa);
    exp_misses++;
    vectors++;
    if (missed !== 1'b1) begin miscompares++; $display("FAIL postflush got missed=%b want=1", missed); end
    @(negedge clk); flush = 1'b1; enable = 1'b1; addr = 64'h1040;
    @(negedge clk); flush = 1'b0; enable = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (done || irequest) seen = 1;
    end
    vectors++;
    if (seen !== 1'b0) begin miscompares++; $display("FAIL flush_beats_enable got activity=%b want=0", seen); end
    check_counts("flush_enable");
    do_access(64'h1040, 1'b0, lat, missed, ra, iaa);
    exp_misses++;
    vectors++;
    if (missed !== 1'b1) begin miscompares++; $display("FAIL flush_again got missed=%b want=1", missed); end
    check_counts("flush");
  endtask

  task automatic test_reset_miss;
    int lat; bit missed; logic [63:0] ra; bit iaa;
    @(negedge clk); enable = 1'b1; addr = 64'h3000;
    @(negedge clk); enable = 1'b0;
    @(negedge clk);
    vectors++;
    if (irequest !== 1'b1) begin miscompares++; $display("FAIL abort_req got=%b want=1", irequest); end
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    vectors++;
    if (irequest !== 1'b0 || done !== 1'b0) begin
      miscompares++; $display("FAIL abort_reset got irequest=%b done=%b want 0/0", irequest, done);
    end
    exp_hits = 0; exp_misses = 0;
    ireqack = 1'b1; idone = 1'b1; idata = {16{32'hDEAD_BEEF}};
    @(negedge clk); ireqack = 1'b0; idone = 1'b0;
    vectors++;
    if (done !== 1'b0 || irequest !== 1'b0) begin
      miscompares++; $display("FAIL late_idone got done=%b irequest=%b want 0/0", done, irequest);
    end
    do_access(64'h3000, 1'b0, lat, missed, ra, iaa);
    exp_misses++;
    vectors++;
    if (missed !== 1'b1 || ra !== 64'h3000) begin
      miscompares++; $display("FAIL after_abort got missed=%b iaddr=%h want 1/3000", missed, ra);
    end
    do_access(64'h1040, 1'b0, lat, missed, ra, iaa);
    exp_misses++;
    vectors++;
    if (missed !== 1'b1) begin miscompares++; $display("FAIL reset_invalidates got missed=%b want=1", missed); end
    check_counts("reset_miss");
  endtask

  initial begin
    test_reset;
    test_cold_miss;
    test_hit;
    test_conflict;
    test_flush;
    test_reset_miss;
    repeat (2) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++; $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/icache_assoc.md
Name: icache_assoc

Overview:
Parameterised set-associative instruction cache between fetch and the memory-request interface. Serves whole cache lines on hits from internal storage. On a miss it fetches the line over the irequest/ireqack/idone handshake, fills a victim way and returns the line. Adds associativity, real hit detection, round-robin replacement, flush and hit/miss counters over the previous pass-through fetch block.

Parameters:
WAYS, 2, number of ways per set (power of two, 1..8)
SET_BITS, 6, log2 of number of sets
OFFSET_BITS, 6, log2 of line bytes (line = 8<<OFFSET_BITS bits = 512)
ADDR_WIDTH, 64, address width
CNT_WIDTH, 32, width of hit/miss counters

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
enable  in  1  fetch request, sampled only in IDLE
addr  in  ADDR_WIDTH  fetch address; offset bits ignored
flush  in  1  invalidate all lines, sampled only in IDLE
rdata  out  8<<OFFSET_BITS  returned line, valid while done=1
done  out  1  one-cycle completion pulse
irequest  out  1  memory request, held until ireqack
ireqack  in  1  memory accepted request
iaddr  out  ADDR_WIDTH  line-aligned miss address
idata  in  8<<OFFSET_BITS  fill line, valid with idone
idone  in  1  fill data valid
hit_count  out  CNT_WIDTH  completed hits, wraps
miss_count  out  CNT_WIDTH  completed misses, wraps

Behaviour:
- Storage per set/way: valid bit, tag (ADDR_WIDTH-SET_BITS-OFFSET_BITS bits), line data. Per set: log2(WAYS)-bit round-robin victim pointer.
- Reset: state IDLE; all valid=0; pointers=0; done=0, rdata=0, irequest=0, iaddr=0, counters=0. A pending miss is abandoned; a later idone is ignored.
- State IDLE: done=0.
  - flush=1 clears all valid bits and pointers in one cycle and stays in IDLE. Flush beats enable in the same cycle; that enable is not accepted.
  - Otherwise enable=1 latches addr with offset forced to 0 and goes to LOOKUP.
- State LOOKUP: compare the latched tag against all ways of the indexed set.
  - Hit (exactly one valid matching way): rdata<=line, done<=1, hit_count+1, go to IDLE. done is high in the cycle after LOOKUP. Hit latency: enable accepted at cycle 0, done high in cycle 2.
  - Miss: irequest<=1, iaddr<=latched line address, go to MISS.
- State MISS:
  - irequest drops on the edge after ireqack=1 is sampled.
  - idone=1, including in the same cycle as ireqack: write idata into the victim way and set valid/tag. rdata<=idata, done<=1, miss_count+1, irequest<=0, go to IDLE.
  - Victim is the lowest-index invalid way if any; otherwise the pointer way, and the pointer increments mod WAYS. The pointer does not move when an invalid way is filled.
- A held enable in the done cycle (state IDLE) starts a new access. The requester must drop enable on done unless it wants another fetch.
- idone/ireqack outside MISS are ignored. enable and flush outside IDLE are ignored.
- A duplicate tag match in a set cannot occur. Behaviour on a duplicate match is unspecified; the bench must flag it as an error.

Test Plan:
- Cold miss: reset, enable addr=0x1040 -> irequest=1, iaddr=0x1040; ack, then idone with idata=pattern A -> done=1 one cycle, rdata=A, miss_count=1.
- Hit after fill: enable addr=0x1040 again -> done in cycle 2 after accept, rdata=A, no irequest, hit_count=1.
- Unaligned address: enable addr=0x1075 after the 0x1040 fill -> hit, rdata=A.
- Conflict with WAYS=2, SET_BITS=6 (set stride 0x1000): fill 0x0000, 0x1000, 0x2000.
  - 0x2000 evicts way0 (0x0000).
  - Re-access 0x1000 -> hit.
  - Re-access 0x0000 -> miss that evicts way1.
- Flush: fill 0x1040, pulse flush, enable 0x1040 -> miss. flush and enable in the same cycle -> no access started.
- Reset during MISS: after irequest, assert reset one cycle -> irequest=0, done=0 next edge. Late idone -> no done, no fill; next access to the same address misses.
